// File: rtl/packet_transmitter.sv
// Buffers a BYTES-wide word and shifts it out on a transmission/clock/out_data link.
// Defining PACKET_TX_PARITY_EN appends an even-parity bit to every byte.
module packet_transmitter #(
  parameter int BYTES     = 8,
  parameter int CLK_DIV   = 16,
  parameter int GAP_BITS  = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*BYTES-1:0] data,
  input  logic               valid,
  output logic               ready,
  output logic               busy,
  output logic               transmission,
  output logic               clock,
  output logic               out_data
);

`ifdef PACKET_TX_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif
  localparam int BIT_W  = $clog2(FRAME_BITS);
  localparam int BYTE_W = $clog2(BYTES + 1);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state;
  logic [8*BYTES-1:0] word_q;
  logic [8*BYTES-1:0] word_next;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BYTE_W-1:0]  byte_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  // The buffer shifts down one byte per byte sent, so the active byte is always word_q[7:0].
  assign word_next = word_q >> 8;
  assign ready     = (state == IDLE);

  function automatic logic frame_bit(input logic [7:0] b, input logic [BIT_W-1:0] idx);
`ifdef PACKET_TX_PARITY_EN
    if (idx == BIT_W'(8)) return ^b;
`endif
    return MSB_FIRST ? b[3'd7 - idx[2:0]] : b[idx[2:0]];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      word_q       <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      busy         <= 1'b0;
      transmission <= 1'b0;
      clock        <= 1'b0;
      out_data     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            state        <= SEND;
            word_q       <= data;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            gap_cnt      <= '0;
            busy         <= 1'b1;
            transmission <= 1'b1;
            clock        <= 1'b0;
            out_data     <= frame_bit(data[7:0], '0);
          end
        end

        SEND: begin
          if (div_cnt != DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= div_cnt + 1'b1;
            // Clock output tracks the divider value it will hold after this edge.
            clock   <= (div_cnt >= DIV_W'(CLK_DIV / 2 - 1));
          end else begin
            div_cnt <= '0;
            clock   <= 1'b0;
            if (bit_cnt != BIT_W'(FRAME_BITS - 1)) begin
              bit_cnt  <= bit_cnt + 1'b1;
              out_data <= frame_bit(word_q[7:0], bit_cnt + 1'b1);
            end else if (byte_cnt == BYTE_W'(BYTES - 1)) begin
              state        <= IDLE;
              bit_cnt      <= '0;
              byte_cnt     <= '0;
              busy         <= 1'b0;
              transmission <= 1'b0;
              out_data     <= 1'b0;
            end else if (GAP_BITS == 0) begin
              word_q   <= word_next;
              byte_cnt <= byte_cnt + 1'b1;
              bit_cnt  <= '0;
              out_data <= frame_bit(word_next[7:0], '0);
            end else begin
              state        <= GAP;
              gap_cnt      <= '0;
              transmission <= 1'b0;
              out_data     <= 1'b0;
            end
          end
        end

        GAP: begin
          if (div_cnt != DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (gap_cnt != GAP_W'(GAP_BITS - 1)) begin
              gap_cnt <= gap_cnt + 1'b1;
            end else begin
              state        <= SEND;
              word_q       <= word_next;
              byte_cnt     <= byte_cnt + 1'b1;
              bit_cnt      <= '0;
              transmission <= 1'b1;
              out_data     <= frame_bit(word_next[7:0], '0);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/packet_transmitter.md
# packet_transmitter

Parametrised successor of the fixed 64-bit data transmitter. Accepts a BYTES-wide word through a valid/ready handshake and buffers it. Shifts it out byte by byte on a three-wire link (transmission, clock, out_data), with a built-in bit-rate divider, selectable bit order and configurable inter-byte gap. Sits between packet-producing logic and the board-level serial pins.

## Interface
- BYTES, default 8: bytes per word; legal range 1..256.
- CLK_DIV, default 16: clk cycles per bit period; must be even and at least 2.
- GAP_BITS, default 1: idle bit periods between consecutive bytes; 0 means back-to-back.
- MSB_FIRST, default 0: 0 sends bit 0 of each byte first; 1 sends bit 7 first.
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- data, input, 8*BYTES: word to send; byte k is data[8k+7:8k]; byte 0 is sent first.
- valid, input, 1: data is valid.
- ready, output, 1: block can accept a word.
- busy, output, 1: a word is being sent, including gaps.
- transmission, output, 1: high while a byte's bits are on the wire.
- clock, output, 1: bit clock; receiver samples out_data on its rising edge.
- out_data, output, 1: serial data.

## Operation
- Reset values: ready=1 (combinational, reflects IDLE); busy, transmission, clock and out_data all 0. The divider, bit counter and byte counter are 0.
- States:
  - IDLE: ready=1.
  - SEND: driving a byte.
  - GAP: inter-byte idle.
- ready = (state==IDLE). busy = (state!=IDLE).
- Accept: on valid&&ready at a rising edge:
  - all BYTES bytes latch into an internal buffer;
  - state goes to SEND, byte 0, bit 0.
- data changes after acceptance are ignored.
- SEND:
  - divider counts 0..CLK_DIV-1;
  - out_data holds the current bit for the whole bit period;
  - clock=1 while divider >= CLK_DIV/2, else 0;
  - transmission=1.
- Frame per byte: 8 data bits in MSB_FIRST order. With PACKET_TX_PARITY_EN, a 9th parity bit follows (see Configuration).
- After the last bit period of a byte:
  - if it is the last byte, go to IDLE;
  - else if GAP_BITS=0, go to SEND for the next byte with no idle cycle;
  - else go to GAP.
- GAP: lasts GAP_BITS*CLK_DIV cycles; transmission, clock and out_data are all 0; then SEND for the next byte.
- Arithmetic:
  - byte counter is ceil(log2(BYTES+1)) bits wide;
  - divider and gap counters saturate at no value, they wrap only by explicit reload;
  - no wrap into a stale buffer index is permitted.
- Reset mid-operation: the word is aborted. All outputs reach reset values at that edge. The buffered word is discarded, never resumed.
- valid while busy: ignored, no queueing. The producer must hold valid until ready.

## Timing
- All outputs except ready are registered.
- Acceptance edge E: at E, transmission=1 and out_data=first bit; clock goes high at E+CLK_DIV/2.
- Bit n of the packet, counted across bytes excluding gaps, begins at E + n*CLK_DIV plus any preceding gap cycles.
- Total busy cycles: BYTES*B*CLK_DIV + (BYTES-1)*GAP_BITS*CLK_DIV, with B=8, or 9 with parity.
- busy falls and ready rises on the same edge that ends the final bit period. A new word can be accepted at that edge+1's sample, so the minimum turnaround is 1 cycle of IDLE.
- transmission falls exactly at the end of each byte's last bit period and rises exactly at the start of the next byte.

## Configuration
- PACKET_TX_PARITY_EN defined:
  - each byte is followed by one even-parity bit (XOR of the 8 data bits);
  - the parity bit is clocked like a data bit with transmission still high;
  - B=9.
- Undefined: no parity bit; B=8; the parity logic is absent from the netlist.

## Test plan
- Reset state: BYTES=2, CLK_DIV=4, GAP_BITS=1, MSB_FIRST=0. Hold rst 3 cycles -> ready=1 and busy, transmission, clock, out_data all 0.
- Basic send, same parameters. data=16'hA55A, valid one cycle -> out_data per bit period is 0,1,0,1,1,0,1,0, then 4 cycles gap, then 1,0,1,0,0,1,0,1. busy is high for exactly 68 cycles. Each bit period has 2 clock-low cycles followed by 2 clock-high cycles.
- Bit order and back-to-back: MSB_FIRST=1, GAP_BITS=0, data=16'h01_80 -> out_data is 1 followed by 7 zeros, then 7 zeros followed by 1. transmission stays high for all 64 cycles.
- Parity: PACKET_TX_PARITY_EN, BYTES=1, data=8'h07 -> 9th bit=1. With data=8'h03 -> 9th bit=0. busy is high for 36 cycles at CLK_DIV=4.
- Handshake: valid held high continuously with changing data -> a new word is accepted only at each IDLE cycle. Mid-packet data changes do not alter the transmitted bits.
- Reset mid-operation: assert rst at bit 5 of byte 1 -> all outputs 0 and ready=1 on the next edge. A fresh send afterwards is bit-exact.
